// File: rtl/lab1_gate_sweeper_if.sv
// lab1_gate_sweeper_if: control, gate drive and result signals between the sweeper and the board/gate
interface lab1_gate_sweeper_if;
  logic start;
  logic abort;
  logic gate_a;
  logic gate_b;
  logic gate_c;
  logic [1:0] vec_idx;
  logic busy;
  logic done;
  logic pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;
  modport master (
    input start, abort, gate_c,
    output gate_a, gate_b, vec_idx, busy, done, pass, fail_mask, err_count
  );
  modport slave (
    output start, abort, gate_c,
    input gate_a, gate_b, vec_idx, busy, done, pass, fail_mask, err_count
  );
endinterface

// File: rtl/lab1_gate_sweeper.sv
// lab1_gate_sweeper: drives all four input vectors into a 2-input gate and checks its output against a truth table
module lab1_gate_sweeper #(
  parameter logic [3:0] EXPECT = 4'b1110,
  parameter int SETTLE = 2,
  parameter int DWELL = 12000000
) (
  input logic clk,
  input logic rst,
  lab1_gate_sweeper_if.master bus
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE_S, SAMPLE, DWELL_S, DONE} state_t;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [23:0] DWELL_LAST = 24'(DWELL - 1);
  state_t state;
  logic [7:0] settle_cnt;
  logic [23:0] dwell_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      settle_cnt <= '0;
      dwell_cnt <= '0;
      bus.gate_a <= 1'b0;
      bus.gate_b <= 1'b0;
      bus.vec_idx <= '0;
      bus.fail_mask <= '0;
      bus.err_count <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
    end else if (bus.abort) begin
      state <= IDLE;
      bus.gate_a <= 1'b0;
      bus.gate_b <= 1'b0;
      bus.vec_idx <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state <= DRIVE;
          bus.vec_idx <= '0;
          bus.fail_mask <= '0;
          bus.err_count <= '0;
          bus.busy <= 1'b1;
          bus.done <= 1'b0;
          bus.pass <= 1'b0;
        end
        DRIVE: begin
          bus.gate_a <= bus.vec_idx[1];
          bus.gate_b <= bus.vec_idx[0];
          settle_cnt <= '0;
          state <= SETTLE_S;
        end
        SETTLE_S: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          if (bus.gate_c != EXPECT[bus.vec_idx]) begin
            bus.fail_mask[bus.vec_idx] <= 1'b1;
            bus.err_count <= bus.err_count + 3'd1;
          end
          dwell_cnt <= '0;
          state <= DWELL_S;
        end
        DWELL_S: begin
          dwell_cnt <= dwell_cnt + 24'd1;
          if (dwell_cnt == DWELL_LAST) begin
            if (bus.vec_idx == 2'd3) begin
              state <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (bus.fail_mask == 4'd0);
            end else begin
              bus.vec_idx <= bus.vec_idx + 2'd1;
              state <= DRIVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
